// File: rtl/i3c_mem_pkg.sv
// Shared types and constants for the I3C controller's table memories (DAT/DCT).
// The sink/source structs are sized for the widest table so one type serves both.
package i3c_mem_pkg;

    localparam int unsigned DatWidth  = 64;
    localparam int unsigned DctWidth  = 128;
    localparam int unsigned MaskGroup = 32;
    localparam int unsigned MemAw     = 8;

    typedef struct packed {
        logic       cfg_en;
        logic [3:0] cfg;
    } ram_1p_cfg_t;

    typedef struct packed {
        logic                req;
        logic                write;
        logic [MemAw-1:0]    addr;
        logic [DctWidth-1:0] wdata;
        logic [DctWidth-1:0] wmask;
    } mem_sink_t;

    typedef struct packed {
        logic [DctWidth-1:0] rdata;
    } mem_src_t;

endpackage

// File: rtl/i3c_mem_1p_core.sv
// Plain single-port storage array: bit-masked write, registered read, full clear on reset.
// Range qualification is done by the wrapper; rclr_i forces a zero read result.
module i3c_mem_1p_core
    import i3c_mem_pkg::*;
#(
    parameter int unsigned Depth = 128,
    parameter int unsigned Width = DatWidth,
    localparam int unsigned Aw   = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic             re_i,
    input  logic             rclr_i,
    input  logic [Aw-1:0]    addr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [Width-1:0] wmask_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [Width-1:0] rdata_q;
    logic [Width-1:0] rdata_d;

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[addr_i] = (mem_q[addr_i] & ~wmask_i) | (wdata_i & wmask_i);
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rclr_i) begin
            rdata_d = '0;
        end else if (re_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q   <= '{default: '0};
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/i3c_mem_1p_adv.sv
// Single-port table RAM for the I3C controller: wraps the core with range checking,
// a one-cycle read-valid strobe, a tied-off error output and parameter sanity checks.
module i3c_mem_1p_adv
    import i3c_mem_pkg::*;
#(
    parameter int unsigned Depth           = 128,
    parameter int unsigned Width           = DatWidth,
    parameter int unsigned DataBitsPerMask = MaskGroup,
    localparam int unsigned Aw             = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             write_i,
    input  logic [Aw-1:0]    addr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [Width-1:0] wmask_i,
    output logic [Width-1:0] rdata_o,
    output logic             rvalid_o,
    output logic [1:0]       rerror_o,
    input  ram_1p_cfg_t      cfg_i
);

    if (Depth < 2) begin : g_bad_depth
        $fatal(1, "i3c_mem_1p_adv: Depth must be at least 2");
    end
    if ((Width % DataBitsPerMask) != 0) begin : g_bad_mask
        $fatal(1, "i3c_mem_1p_adv: DataBitsPerMask must divide Width");
    end

    // One extra bit so a power-of-two Depth is representable for the compare.
    localparam logic [Aw:0] DepthLim = Depth[Aw:0];

    logic       in_range;
    logic       core_we;
    logic       core_re;
    logic       core_rclr;
    logic       rvalid_q;
    logic       rvalid_d;
    logic [1:0] rerror_q;
    logic [1:0] rerror_d;
    logic       unused_cfg;

    always_comb begin
        in_range  = ({1'b0, addr_i} < DepthLim);
        core_we   = req_i & write_i & in_range;
        core_re   = req_i & ~write_i & in_range;
        core_rclr = req_i & ~write_i & ~in_range;
    end

    always_comb begin
        rvalid_d = req_i & ~write_i;
        rerror_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rerror_q <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rerror_q <= rerror_d;
        end
    end

    i3c_mem_1p_core #(
        .Depth (Depth),
        .Width (Width)
    ) u_core (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (core_we),
        .re_i    (core_re),
        .rclr_i  (core_rclr),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .wmask_i (wmask_i),
        .rdata_o (rdata_o)
    );

    assign rvalid_o   = rvalid_q;
    assign rerror_o   = rerror_q;
    assign unused_cfg = ^{cfg_i.cfg_en, cfg_i.cfg};

endmodule

// File: tb/tb_i3c_mem_1p_adv.sv
// Directed bench for i3c_mem_1p_adv: default 128x64, a 128x128 and a 5x64 instance.
module tb_i3c_mem_1p_adv;
    import i3c_mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    ram_1p_cfg_t cfg = '0;

    // Instance A: Depth 128, Width 64
    logic         a_rst_n, a_req, a_write;
    logic [6:0]   a_addr;
    logic [63:0]  a_wdata, a_wmask, a_rdata;
    logic         a_rvalid;
    logic [1:0]   a_rerror;

    // Instance B: Depth 128, Width 128
    logic         b_rst_n, b_req, b_write;
    logic [6:0]   b_addr;
    logic [127:0] b_wdata, b_wmask, b_rdata;
    logic         b_rvalid;
    logic [1:0]   b_rerror;

    // Instance C: Depth 5, Width 64
    logic         c_rst_n, c_req, c_write;
    logic [2:0]   c_addr;
    logic [63:0]  c_wdata, c_wmask, c_rdata;
    logic         c_rvalid;
    logic [1:0]   c_rerror;

    i3c_mem_1p_adv dut_a (
        .clk_i(clk), .rst_ni(a_rst_n), .req_i(a_req), .write_i(a_write), .addr_i(a_addr),
        .wdata_i(a_wdata), .wmask_i(a_wmask), .rdata_o(a_rdata), .rvalid_o(a_rvalid),
        .rerror_o(a_rerror), .cfg_i(cfg)
    );

    i3c_mem_1p_adv #(.Depth(128), .Width(128)) dut_b (
        .clk_i(clk), .rst_ni(b_rst_n), .req_i(b_req), .write_i(b_write), .addr_i(b_addr),
        .wdata_i(b_wdata), .wmask_i(b_wmask), .rdata_o(b_rdata), .rvalid_o(b_rvalid),
        .rerror_o(b_rerror), .cfg_i(cfg)
    );

    i3c_mem_1p_adv #(.Depth(5), .Width(64)) dut_c (
        .clk_i(clk), .rst_ni(c_rst_n), .req_i(c_req), .write_i(c_write), .addr_i(c_addr),
        .wdata_i(c_wdata), .wmask_i(c_wmask), .rdata_o(c_rdata), .rvalid_o(c_rvalid),
        .rerror_o(c_rerror), .cfg_i(cfg)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic a_op(input logic req, input logic wr, input logic [6:0] addr,
                        input logic [63:0] wdata, input logic [63:0] wmask);
        a_req = req; a_write = wr; a_addr = addr; a_wdata = wdata; a_wmask = wmask;
        step();
    endtask

    task automatic b_op(input logic req, input logic wr, input logic [6:0] addr,
                        input logic [127:0] wdata, input logic [127:0] wmask);
        b_req = req; b_write = wr; b_addr = addr; b_wdata = wdata; b_wmask = wmask;
        step();
    endtask

    task automatic c_op(input logic req, input logic wr, input logic [2:0] addr,
                        input logic [63:0] wdata, input logic [63:0] wmask);
        c_req = req; c_write = wr; c_addr = addr; c_wdata = wdata; c_wmask = wmask;
        step();
    endtask

    localparam logic [63:0] Ones64 = '1;

    initial begin
        a_rst_n = 1'b0; a_req = 1'b1; a_write = 1'b0; a_addr = 7'd5; a_wdata = '0; a_wmask = '0;
        b_rst_n = 1'b0; b_req = 1'b1; b_write = 1'b0; b_addr = 7'd5; b_wdata = '0; b_wmask = '0;
        c_rst_n = 1'b0; c_req = 1'b1; c_write = 1'b0; c_addr = 3'd1; c_wdata = '0; c_wmask = '0;

        // 1. reset held for 3 clocks with requests present
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", {127'd0, a_rvalid}, 128'd0);
        chk("rst_rdata", {64'd0, a_rdata}, 128'd0);
        chk("rst_rerror", {126'd0, a_rerror}, 128'd0);
        chk("rst_b_rvalid", {127'd0, b_rvalid}, 128'd0);
        chk("rst_c_rvalid", {127'd0, c_rvalid}, 128'd0);
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
        b_req = 1'b0; c_req = 1'b0;

        a_op(1'b1, 1'b0, 7'd5, '0, '0);
        chk("rd5_rdata", {64'd0, a_rdata}, 128'd0);
        chk("rd5_rvalid", {127'd0, a_rvalid}, 128'd1);
        chk("rd5_rerror", {126'd0, a_rerror}, 128'd0);

        // 2. full write then read
        a_op(1'b1, 1'b1, 7'd3, 64'hDEAD_BEEF_CAFE_F00D, Ones64);
        chk("wr3_rvalid", {127'd0, a_rvalid}, 128'd0);
        chk("wr3_rdata_hold", {64'd0, a_rdata}, 128'd0);
        a_op(1'b1, 1'b0, 7'd3, '0, '0);
        chk("rd3_rdata", {64'd0, a_rdata}, {64'd0, 64'hDEAD_BEEF_CAFE_F00D});
        chk("rd3_rvalid", {127'd0, a_rvalid}, 128'd1);
        a_op(1'b0, 1'b1, 7'd3, Ones64, Ones64);
        chk("idle_rvalid_pulse", {127'd0, a_rvalid}, 128'd0);
        chk("idle_rdata_hold", {64'd0, a_rdata}, {64'd0, 64'hDEAD_BEEF_CAFE_F00D});

        // 3. group-masked write, then a mixed in-group mask applied bit by bit
        a_op(1'b1, 1'b1, 7'd3, 64'h1111_1111_2222_2222, 64'h0000_0000_FFFF_FFFF);
        a_op(1'b1, 1'b0, 7'd3, '0, '0);
        chk("mask_lo", {64'd0, a_rdata}, {64'd0, 64'hDEAD_BEEF_2222_2222});
        a_op(1'b1, 1'b1, 7'd3, Ones64, 64'h0000_0000_0000_00F0);
        a_op(1'b1, 1'b0, 7'd3, '0, '0);
        chk("mask_bits", {64'd0, a_rdata}, {64'd0, 64'hDEAD_BEEF_2222_22F2});

        // 4. back-to-back reads
        a_op(1'b1, 1'b1, 7'd0, 64'd10, Ones64);
        a_op(1'b1, 1'b1, 7'd1, 64'd11, Ones64);
        a_op(1'b1, 1'b1, 7'd2, 64'd12, Ones64);
        a_op(1'b1, 1'b0, 7'd0, '0, '0);
        chk("b2b0_rdata", {64'd0, a_rdata}, 128'd10);
        chk("b2b0_rvalid", {127'd0, a_rvalid}, 128'd1);
        a_op(1'b1, 1'b0, 7'd1, '0, '0);
        chk("b2b1_rdata", {64'd0, a_rdata}, 128'd11);
        chk("b2b1_rvalid", {127'd0, a_rvalid}, 128'd1);
        a_op(1'b1, 1'b0, 7'd2, '0, '0);
        chk("b2b2_rdata", {64'd0, a_rdata}, 128'd12);
        chk("b2b2_rvalid", {127'd0, a_rvalid}, 128'd1);
        a_op(1'b0, 1'b0, 7'd0, '0, '0);
        chk("b2b_idle_rvalid", {127'd0, a_rvalid}, 128'd0);
        chk("b2b_idle_rdata", {64'd0, a_rdata}, 128'd12);

        // 5a. 128-bit words: top address and write-then-read at addr 0
        b_op(1'b1, 1'b1, 7'd127, 128'h1, '1);
        b_op(1'b1, 1'b0, 7'd127, '0, '0);
        chk("w128_a127", b_rdata, 128'h1);
        chk("w128_a127_rvalid", {127'd0, b_rvalid}, 128'd1);
        b_op(1'b1, 1'b1, 7'd0, 128'hA5A5_0000_1234_5678_9ABC_DEF0_0F0F_C3C3, '1);
        b_op(1'b1, 1'b0, 7'd0, '0, '0);
        chk("w128_a0_raw", b_rdata, 128'hA5A5_0000_1234_5678_9ABC_DEF0_0F0F_C3C3);
        b_op(1'b1, 1'b1, 7'd0, 128'hFFFF_FFFF_0000_0000_0000_0000_0000_0000,
             128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000);
        b_op(1'b1, 1'b0, 7'd0, '0, '0);
        chk("w128_a0_mask", b_rdata, 128'hFFFF_FFFF_0000_0000_9ABC_DEF0_0F0F_C3C3);
        chk("w128_rerror", {126'd0, b_rerror}, 128'd0);

        // 5b. Depth 5: out-of-range write ignored, read returns zero with valid
        c_op(1'b1, 1'b1, 3'd4, 64'h55, Ones64);
        c_op(1'b1, 1'b1, 3'd6, 64'hFF, Ones64);
        c_op(1'b1, 1'b0, 3'd4, '0, '0);
        chk("d5_rd4", {64'd0, c_rdata}, 128'h55);
        c_op(1'b1, 1'b0, 3'd6, '0, '0);
        chk("d5_rd6_rdata", {64'd0, c_rdata}, 128'd0);
        chk("d5_rd6_rvalid", {127'd0, c_rvalid}, 128'd1);
        chk("d5_rd6_rerror", {126'd0, c_rerror}, 128'd0);
        c_op(1'b1, 1'b0, 3'd2, '0, '0);
        chk("d5_rd2", {64'd0, c_rdata}, 128'd0);
        c_op(1'b1, 1'b0, 3'd4, '0, '0);
        chk("d5_rd4_again", {64'd0, c_rdata}, 128'h55);

        // 6. reset in the cycle a read is issued
        a_op(1'b1, 1'b1, 7'd2, 64'd7, Ones64);
        a_rst_n = 1'b0;
        a_op(1'b1, 1'b0, 7'd2, '0, '0);
        chk("midrst_rvalid", {127'd0, a_rvalid}, 128'd0);
        chk("midrst_rdata", {64'd0, a_rdata}, 128'd0);
        a_rst_n = 1'b1;
        a_op(1'b1, 1'b0, 7'd3, '0, '0);
        chk("midrst_rd3_cleared", {64'd0, a_rdata}, 128'd0);
        a_op(1'b1, 1'b0, 7'd2, '0, '0);
        chk("midrst_rd2_cleared", {64'd0, a_rdata}, 128'd0);
        chk("midrst_rd2_rvalid", {127'd0, a_rvalid}, 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
